// File: rtl/fifo_flush_seq.sv
// Flush sequencer for the dual-clock FIFO: it gates data traffic, waits a quiesce interval,
// holds flush, then waits for a synchronized empty, and reports done or timeout through sticky bits.
module fifo_flush_seq #(
    parameter int QUIESCE_CYC = 4,
    parameter int FLUSH_HOLD  = 8,
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic       csr_clk,
    input  logic       csr_resetn,
    input  logic       flush_req,
    input  logic       abort,
    input  logic       sticky_clr,
    input  logic [1:0] irq_en,
    input  logic       fifo_empty_async,
    input  logic       fifo_full_async,
    output logic       empty_sync,
    output logic       full_sync,
    output logic       flush,
    output logic       data_gate,
    output logic       busy,
    output logic       done_pulse,
    output logic       done_sticky,
    output logic       err_sticky,
    output logic       irq
);

    localparam int CNT_MAX = (QUIESCE_CYC > FLUSH_HOLD)
                           ? ((QUIESCE_CYC > TIMEOUT) ? QUIESCE_CYC : TIMEOUT)
                           : ((FLUSH_HOLD  > TIMEOUT) ? FLUSH_HOLD  : TIMEOUT);
    localparam int CNT_W = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] Q_LAST = CNT_W'(QUIESCE_CYC - 1);
    localparam logic [CNT_W-1:0] F_LAST = CNT_W'(FLUSH_HOLD - 1);
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUIESCE,
        S_FLUSH,
        S_WAIT_EMPTY,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SYNC_STAGES-1:0] empty_pipe;
    logic [SYNC_STAGES-1:0] full_pipe;
    logic             done_set;
    logic             err_set;

    // {busy, data_gate, flush, done_pulse} for the state being entered
    function automatic logic [3:0] moore_out(input state_t s);
        case (s)
            S_QUIESCE:    moore_out = 4'b1100;
            S_FLUSH:      moore_out = 4'b1110;
            S_WAIT_EMPTY: moore_out = 4'b1100;
            S_DONE:       moore_out = 4'b1101;
            default:      moore_out = 4'b0000;
        endcase
    endfunction

    assign empty_sync = empty_pipe[SYNC_STAGES-1];
    assign full_sync  = full_pipe[SYNC_STAGES-1];

    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            empty_pipe <= '0;
            full_pipe  <= '0;
        end else begin
            empty_pipe <= {empty_pipe[SYNC_STAGES-2:0], fifo_empty_async};
            full_pipe  <= {full_pipe[SYNC_STAGES-2:0], fifo_full_async};
        end
    end

    // Completion and timeout events both need an unaborted exit edge
    assign done_set = (state == S_DONE) && !abort;
    assign err_set  = (state == S_WAIT_EMPTY) && !abort && !empty_sync && (cnt == T_LAST);

    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            state <= S_IDLE;
            cnt   <= '0;
            {busy, data_gate, flush, done_pulse} <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_req && !abort) begin
                        state <= S_QUIESCE;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_QUIESCE);
                    end
                end
                S_QUIESCE: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_IDLE);
                    end else if (cnt == Q_LAST) begin
                        state <= S_FLUSH;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_FLUSH);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (abort) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_IDLE);
                    end else if (cnt == F_LAST) begin
                        state <= S_WAIT_EMPTY;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_WAIT_EMPTY);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_EMPTY: begin
                    if (abort || err_set) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_IDLE);
                    end else if (empty_sync) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        {busy, data_gate, flush, done_pulse} <= moore_out(S_DONE);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    {busy, data_gate, flush, done_pulse} <= moore_out(S_IDLE);
                end
            endcase
        end
    end

    // A set event outranks a clear arriving on the same edge
    always_ff @(posedge csr_clk or negedge csr_resetn) begin
        if (!csr_resetn) begin
            done_sticky <= 1'b0;
            err_sticky  <= 1'b0;
            irq         <= 1'b0;
        end else begin
            done_sticky <= done_set | (done_sticky & ~sticky_clr);
            err_sticky  <= err_set  | (err_sticky  & ~sticky_clr);
            irq         <= (done_sticky & irq_en[0]) | (err_sticky & irq_en[1]);
        end
    end

endmodule

// File: tb/tb_fifo_flush_seq.sv
// Directed bench for fifo_flush_seq: per-cycle expected status vectors are queued when a
// sequence is launched and popped against the DUT one cycle at a time.
module tb_fifo_flush_seq;

    localparam int Q = 4;
    localparam int F = 8;
    localparam int T = 64;

    logic       csr_clk;
    logic       csr_resetn;
    logic       flush_req;
    logic       abort;
    logic       sticky_clr;
    logic [1:0] irq_en;
    logic       fifo_empty_async;
    logic       fifo_full_async;
    logic       empty_sync;
    logic       full_sync;
    logic       flush;
    logic       data_gate;
    logic       busy;
    logic       done_pulse;
    logic       done_sticky;
    logic       err_sticky;
    logic       irq;

    int errors = 0;
    int checks = 0;
    logic exp_dsk = 1'b0;
    logic exp_esk = 1'b0;
    logic [6:0] exp_q[$];

    fifo_flush_seq #(
        .QUIESCE_CYC(Q),
        .FLUSH_HOLD (F),
        .TIMEOUT    (T),
        .SYNC_STAGES(2)
    ) dut (
        .csr_clk         (csr_clk),
        .csr_resetn      (csr_resetn),
        .flush_req       (flush_req),
        .abort           (abort),
        .sticky_clr      (sticky_clr),
        .irq_en          (irq_en),
        .fifo_empty_async(fifo_empty_async),
        .fifo_full_async (fifo_full_async),
        .empty_sync      (empty_sync),
        .full_sync       (full_sync),
        .flush           (flush),
        .data_gate       (data_gate),
        .busy            (busy),
        .done_pulse      (done_pulse),
        .done_sticky     (done_sticky),
        .err_sticky      (err_sticky),
        .irq             (irq)
    );

    initial csr_clk = 1'b0;
    always #5 csr_clk = ~csr_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge csr_clk);
        #1;
    endtask

    task automatic clear_sticky();
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        step();
        step();
        exp_dsk = 1'b0;
        exp_esk = 1'b0;
    endtask

    // Launch flush_req at the current cycle (cycle 0) and check cycles 1..n.
    // w = WAIT_EMPTY cycles before leaving; completes = leaves via DONE rather than timeout.
    task automatic run_seq(input string name, input int n, input int w, input bit completes,
                           input int abort_at, input int req_a, input int req_b,
                           input int clr_a, input int clr_b, output int npulse);
        int   we;
        int   act_end;
        int   k;
        logic dsk;
        logic esk;
        logic irq_m;
        logic noab;
        logic set_d;
        logic set_e;
        logic clr;
        logic bsy;
        logic fl;
        logic dp;
        logic [6:0] exp_v;
        logic [6:0] obs_v;
        we      = Q + F + w;
        act_end = completes ? we + 1 : we;
        dsk     = exp_dsk;
        esk     = exp_esk;
        exp_q.delete();
        for (int c = 1; c <= n; c++) begin
            k     = c - 1;
            noab  = (abort_at < 0) || (abort_at > k);
            set_d = completes && (k == we + 1) && noab;
            set_e = !completes && (k == we) && noab;
            clr   = (k == clr_a) || (k == clr_b);
            irq_m = (dsk & irq_en[0]) | (esk & irq_en[1]);
            dsk   = set_d | (dsk & !clr);
            esk   = set_e | (esk & !clr);
            bsy   = (c <= act_end) && noab;
            fl    = (c >= Q + 1) && (c <= Q + F) && noab;
            dp    = completes && (c == we + 1) && noab;
            exp_q.push_back({bsy, bsy, fl, dp, dsk, esk, irq_m});
        end
        exp_dsk    = dsk;
        exp_esk    = esk;
        npulse     = 0;
        flush_req  = 1'b1;
        abort      = (abort_at == 0);
        sticky_clr = (clr_a == 0) || (clr_b == 0);
        for (int c = 1; c <= n; c++) begin
            step();
            exp_v = exp_q.pop_front();
            obs_v = {busy, data_gate, flush, done_pulse, done_sticky, err_sticky, irq};
            if (done_pulse === 1'b1) npulse++;
            chk($sformatf("%s_cyc%0d", name, c), 32'(obs_v), 32'(exp_v));
            flush_req  = (c == req_a) || (c == req_b);
            abort      = (c == abort_at);
            sticky_clr = (c == clr_a) || (c == clr_b);
        end
        flush_req  = 1'b0;
        abort      = 1'b0;
        sticky_clr = 1'b0;
    endtask

    initial begin
        int np;
        csr_resetn       = 1'b0;
        flush_req        = 1'b0;
        abort            = 1'b0;
        sticky_clr       = 1'b0;
        irq_en           = 2'b01;
        fifo_empty_async = 1'b1;
        fifo_full_async  = 1'b0;
        #23;
        chk("reset_outputs", 32'({empty_sync, full_sync, flush, data_gate, busy, done_pulse,
                                  done_sticky, err_sticky, irq}), 32'd0);
        csr_resetn = 1'b1;
        step();
        step();
        step();
        chk("empty_sync_settled", 32'(empty_sync), 32'd1);

        // Nominal flush with empty already asserted
        run_seq("nominal", 16, 1, 1'b1, -1, -1, -1, -1, -1, np);
        chk("nominal_pulses", 32'(np), 32'd1);
        clear_sticky();
        chk("clear_done", 32'({done_sticky, irq}), 32'd0);

        // Timeout: empty never arrives
        fifo_empty_async = 1'b0;
        step();
        step();
        step();
        run_seq("timeout", 80, T, 1'b0, -1, -1, -1, -1, -1, np);
        chk("timeout_no_pulse", 32'(np), 32'd0);
        irq_en = 2'b10;
        step();
        chk("timeout_irq_err_en", 32'(irq), 32'd1);
        clear_sticky();
        irq_en = 2'b01;
        step();
        chk("timeout_cleared", 32'({err_sticky, irq}), 32'd0);

        // Abort during FLUSH, then a full restart at cycle 10
        fifo_empty_async = 1'b1;
        step();
        step();
        step();
        run_seq("abort", 9, 1, 1'b1, 7, -1, -1, -1, -1, np);
        step();
        run_seq("restart", 16, 1, 1'b1, -1, -1, -1, -1, -1, np);
        chk("restart_pulses", 32'(np), 32'd1);
        clear_sticky();

        // Requests while busy are dropped
        run_seq("ignore_req", 24, 1, 1'b1, -1, 3, 9, -1, -1, np);
        chk("ignore_req_pulses", 32'(np), 32'd1);
        clear_sticky();

        // sticky_clr racing the DONE exit edge, then a lone clear
        run_seq("clr_race", 18, 1, 1'b1, -1, -1, -1, 14, 15, np);
        chk("clr_race_final", 32'({done_sticky, irq}), 32'd0);

        // Synchronizer latency on the full flag
        fifo_full_async = 1'b1;
        step();
        chk("full_sync_edge1", 32'(full_sync), 32'd0);
        step();
        chk("full_sync_edge2", 32'(full_sync), 32'd1);
        fifo_full_async = 1'b0;
        step();
        step();
        chk("full_sync_fall", 32'(full_sync), 32'd0);

        // Reset in the middle of WAIT_EMPTY
        fifo_full_async  = 1'b1;
        fifo_empty_async = 1'b0;
        step();
        step();
        step();
        run_seq("pre_reset", 20, T, 1'b0, -1, -1, -1, -1, -1, np);
        chk("pre_reset_state", 32'({busy, data_gate, full_sync}), 32'b111);
        #2;
        csr_resetn = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({empty_sync, full_sync, flush, data_gate, busy, done_pulse,
                                        done_sticky, err_sticky, irq}), 32'd0);
        #4;
        csr_resetn = 1'b1;
        for (int i = 0; i < 80; i++) step();
        chk("post_reset_quiet", 32'({busy, done_sticky, err_sticky, irq}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
